// File: rtl/cacode_sched.sv
// Round-robin scheduler that time-shares one C/A code generator among four requesters,
// sequencing generator reset, one full code epoch of chips, and completion signalling.
module cacode_sched #(
  parameter int unsigned CODE_LEN = 1023,
  parameter int unsigned LOAD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [23:0] prn_bus,
  input  logic        abort,
  output logic [3:0]  gnt,
  output logic        err,
  output logic        busy,
  output logic        cac_rst,
  output logic [5:0]  cac_prn,
  output logic        cac_enb,
  input  logic        cac_chip,
  output logic        chip_out,
  output logic        chip_valid,
  output logic [1:0]  chip_id,
  output logic        epoch,
  output logic        done
);

  localparam int unsigned CntW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam logic [CntW-1:0] LastChip = CntW'(CODE_LEN - 1);
  localparam logic [3:0] LoadLast = 4'(LOAD_CYC - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e          state_q;
  logic [1:0]      last_grant_q;
  logic [CntW-1:0] chip_cnt_q;
  logic [3:0]      load_cnt_q;

  logic       found;
  logic [1:0] pick;
  logic [1:0] cand;
  logic [5:0] prn_sel;
  logic       prn_ok;

  // Search starts just past the most recent grant so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    cand  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    prn_sel = 6'd0;
    unique case (pick)
      2'd0: prn_sel = prn_bus[5:0];
      2'd1: prn_sel = prn_bus[11:6];
      2'd2: prn_sel = prn_bus[17:12];
      2'd3: prn_sel = prn_bus[23:18];
    endcase
  end

  assign prn_ok = (prn_sel != 6'd0) && (prn_sel <= 6'd32);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= 2'd3;
      chip_cnt_q   <= '0;
      load_cnt_q   <= '0;
      gnt          <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      cac_rst      <= 1'b1;
      cac_prn      <= '0;
      cac_enb      <= 1'b0;
      chip_out     <= 1'b0;
      chip_valid   <= 1'b0;
      chip_id      <= '0;
      epoch        <= 1'b0;
      done         <= 1'b0;
    end else begin
      gnt        <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
      epoch      <= 1'b0;
      chip_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cac_rst <= 1'b0;
          cac_enb <= 1'b0;
          busy    <= 1'b0;
          if (found) begin
            gnt          <= 4'b0001 << pick;
            last_grant_q <= pick;
            cac_prn      <= prn_sel;
            chip_id      <= pick;
            if (prn_ok) begin
              state_q    <= StLoad;
              cac_rst    <= 1'b1;
              busy       <= 1'b1;
              load_cnt_q <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (abort) begin
            state_q <= StIdle;
            cac_rst <= 1'b0;
            busy    <= 1'b0;
          end else if (load_cnt_q == LoadLast) begin
            state_q    <= StRun;
            cac_rst    <= 1'b0;
            cac_enb    <= 1'b1;
            chip_cnt_q <= '0;
          end else begin
            load_cnt_q <= load_cnt_q + 4'd1;
          end
        end
        StRun: begin
          // An aborted cycle's chip is dropped rather than emitted.
          if (abort) begin
            state_q <= StIdle;
            cac_enb <= 1'b0;
            busy    <= 1'b0;
          end else begin
            chip_out   <= cac_chip;
            chip_valid <= 1'b1;
            epoch      <= (chip_cnt_q == LastChip);
            chip_cnt_q <= chip_cnt_q + 1'b1;
            if (chip_cnt_q == LastChip) begin
              state_q <= StDone;
              cac_enb <= 1'b0;
              busy    <= 1'b0;
            end
          end
        end
        StDone: begin
          done    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacode_sched.sv
// Directed bench for cacode_sched: grant table, full epochs against a modelled generator,
// abort, and asynchronous reset mid-epoch.
module tb_cacode_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req;
  logic [23:0] prn_bus;
  logic        abort;
  logic [3:0]  gnt;
  logic        err, busy, cac_rst, cac_enb, cac_chip;
  logic [5:0]  cac_prn;
  logic        chip_out, chip_valid, epoch, done;
  logic [1:0]  chip_id;

  int n_checks = 0;
  int n_fail   = 0;

  cacode_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .prn_bus   (prn_bus),
    .abort     (abort),
    .gnt       (gnt),
    .err       (err),
    .busy      (busy),
    .cac_rst   (cac_rst),
    .cac_prn   (cac_prn),
    .cac_enb   (cac_enb),
    .cac_chip  (cac_chip),
    .chip_out  (chip_out),
    .chip_valid(chip_valid),
    .chip_id   (chip_id),
    .epoch     (epoch),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Stand-in for the code generator: chip value is a fixed function of chips advanced.
  logic [15:0] gen_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst)         gen_cnt <= '0;
    else if (cac_rst) gen_cnt <= '0;
    else if (cac_enb) gen_cnt <= gen_cnt + 16'd1;
  end

  function automatic logic chip_fn(input int k);
    logic [15:0] v;
    v = 16'(k);
    return v[0] ^ v[2] ^ (v[5] & v[1]) ^ v[8];
  endfunction

  assign cac_chip = chip_fn(int'(gen_cnt));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] outs();
    return {gnt, err, busy, cac_rst, cac_prn, cac_enb, chip_out, chip_valid, chip_id, epoch, done};
  endfunction

  localparam logic [19:0] ResetOuts = 20'h02000;

  int rst_cyc, enb_cyc, beats, bad, epoch_beat, done_gap, prn_chg;

  // Follows one epoch from the grant sample until done (or a few cycles past an abort).
  task automatic epoch_run(input int abort_at, input logic [1:0] exp_id, input bit perturb);
    int epoch_cyc;
    int after_abort;
    logic [5:0] prn0;
    rst_cyc = 0; enb_cyc = 0; beats = 0; bad = 0; prn_chg = 0;
    epoch_beat = -1; done_gap = -1; epoch_cyc = -1; after_abort = -1;
    prn0 = cac_prn;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if (cac_rst) rst_cyc++;
      if (cac_prn !== prn0) prn_chg++;
      if (chip_valid) begin
        if (chip_out !== chip_fn(beats) || chip_id !== exp_id) bad++;
        if (epoch) begin
          epoch_beat = beats;
          epoch_cyc  = cyc;
        end
        beats++;
      end else if (epoch) begin
        bad++;
      end
      if (done) begin
        done_gap = cyc - epoch_cyc;
        break;
      end
      if (perturb && cyc == 300) prn_bus = ~prn_bus;
      abort = 1'b0;
      if (cac_enb) begin
        if (enb_cyc == abort_at) begin
          abort       = 1'b1;
          after_abort = 0;
        end
        enb_cyc++;
      end
      if (after_abort >= 0) begin
        if (after_abort == 6) break;
        after_abort++;
      end
      tick();
    end
    abort = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [23:0] prn;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic        err;
    logic [5:0]  prn_out;
  } vec_t;

  vec_t vt[6];

  initial begin
    int cnt;
    vt[0] = '{4'b0001, {6'd0,  6'd0,  6'd0, 6'd1},  4'b0001, 2'd0, 1'b0, 6'd1};
    vt[1] = '{4'b0010, {6'd0,  6'd0,  6'd0, 6'd3},  4'b0010, 2'd1, 1'b1, 6'd0};
    vt[2] = '{4'b0110, {6'd0,  6'd32, 6'd5, 6'd0},  4'b0100, 2'd2, 1'b0, 6'd32};
    vt[3] = '{4'b0011, {6'd0,  6'd0,  6'd0, 6'd40}, 4'b0001, 2'd0, 1'b1, 6'd40};
    vt[4] = '{4'b1001, {6'd33, 6'd0,  6'd0, 6'd7},  4'b1000, 2'd3, 1'b1, 6'd33};
    vt[5] = '{4'b1000, {6'd63, 6'd0,  6'd0, 6'd0},  4'b1000, 2'd3, 1'b1, 6'd63};

    req = '0; prn_bus = '0; abort = 1'b0; rst = 1'b0;
    #12;
    check("reset_outs", 32'(outs()), 32'(ResetOuts));
    rst = 1'b1;
    tick();
    check("cac_rst_release", 32'(cac_rst), 0);

    for (int i = 0; i < 6; i++) begin
      req = vt[i].req;
      prn_bus = vt[i].prn;
      tick();
      req = '0;
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
      check($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].err));
      check($sformatf("v%0d_prn", i), 32'(cac_prn), 32'(vt[i].prn_out));
      check($sformatf("v%0d_id", i), 32'(chip_id), 32'(vt[i].id));
      check($sformatf("v%0d_cac_rst", i), 32'(cac_rst), 32'(!vt[i].err));
      if (!vt[i].err) begin
        epoch_run(-1, vt[i].id, i == 0);
        check($sformatf("v%0d_rst_cyc", i), rst_cyc, 2);
        check($sformatf("v%0d_enb_cyc", i), enb_cyc, 1023);
        check($sformatf("v%0d_beats", i), beats, 1023);
        check($sformatf("v%0d_bad", i), bad, 0);
        check($sformatf("v%0d_epoch_beat", i), epoch_beat, 1022);
        check($sformatf("v%0d_done_gap", i), done_gap, 1);
        check($sformatf("v%0d_prn_chg", i), prn_chg, 0);
      end
      tick();
      check($sformatf("v%0d_idle", i), 32'({busy, cac_rst, cac_enb, gnt}), 0);
    end

    // Held requests from everyone: strict rotation 0,1,2,3,0 with one IDLE gap each time.
    prn_bus = {6'd4, 6'd3, 6'd2, 6'd1};
    req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      if (n == 4) req = '0;
      check($sformatf("rr%0d_gnt", n), 32'(gnt), 32'(4'b0001 << (n % 4)));
      check($sformatf("rr%0d_prn", n), 32'(cac_prn), (n % 4) + 1);
      epoch_run(-1, 2'(n % 4), 1'b0);
      check($sformatf("rr%0d_beats", n), beats, 1023);
      check($sformatf("rr%0d_bad", n), bad, 0);
      check($sformatf("rr%0d_done_gap", n), done_gap, 1);
      tick();
    end
    check("rr_no_regrant", 32'(gnt), 0);

    // Abort at chip 500.
    prn_bus = {18'd0, 6'd9};
    req = 4'b0001;
    tick();
    req = '0;
    check("ab_gnt", 32'(gnt), 32'(4'b0001));
    epoch_run(500, 2'd0, 1'b0);
    check("ab_enb_cyc", enb_cyc, 501);
    check("ab_beats", beats, 500);
    check("ab_bad", bad, 0);
    check("ab_no_epoch", epoch_beat, -1);
    check("ab_no_done", done_gap, -1);
    check("ab_idle", 32'({busy, cac_enb, cac_rst}), 0);

    // Abort during IDLE is ignored; the same abort held into LOAD cancels.
    prn_bus = {6'd0, 6'd11, 12'd0};
    req = 4'b0100;
    abort = 1'b1;
    tick();
    req = '0;
    check("ab2_gnt", 32'(gnt), 32'(4'b0100));
    check("ab2_load", 32'({busy, cac_rst}), 32'(2'b11));
    tick();
    abort = 1'b0;
    check("ab2_cancel", 32'({busy, cac_rst, cac_enb}), 0);
    tick();
    check("ab2_no_regrant", 32'({gnt, cac_enb}), 0);

    // Asynchronous reset at chip 200.
    prn_bus = {18'd0, 6'd1};
    req = 4'b0001;
    tick();
    req = '0;
    check("rs_gnt", 32'(gnt), 32'(4'b0001));
    cnt = 0;
    for (int c = 0; c < 400 && cnt < 200; c++) begin
      tick();
      if (chip_valid) cnt++;
    end
    check("rs_beats_before", cnt, 200);
    #2 rst = 1'b0;
    #1 check("rs_async_outs", 32'(outs()), 32'(ResetOuts));
    #2 rst = 1'b1;
    tick();
    check("rs_release", 32'({cac_rst, done, busy}), 0);
    req = 4'b0001;
    tick();
    req = '0;
    check("rs_gnt_after", 32'(gnt), 32'(4'b0001));
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done) cnt++;
    end
    check("rs_no_done", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cacode_sched.md
CACODE_SCHED -- requirements
Module: cacode_sched

Interface
REQ-001 SHALL have parameter CODE_LEN, default 1023; chips per code epoch.
REQ-002 SHALL have parameter LOAD_CYC, default 2; cycles generator reset is held; legal range 1..15.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port req  in  4  per-requester code-epoch request, level-sensitive.
REQ-006 SHALL have port prn_bus  in  24  requester i PRN in bits [6i+5:6i].
REQ-007 SHALL have port abort  in  1  cancel current epoch.
REQ-008 SHALL have port gnt  out  4  one-hot, one-cycle grant pulse.
REQ-009 SHALL have port err  out  1  one-cycle pulse: granted PRN invalid.
REQ-010 SHALL have port busy  out  1  high in LOAD or RUN.
REQ-011 SHALL have port cac_rst  out  1  active-high reset to shared C/A code generator.
REQ-012 SHALL have port cac_prn  out  6  PRN to generator.
REQ-013 SHALL have port cac_enb  out  1  chip-advance enable to generator.
REQ-014 SHALL have port cac_chip  in  1  current chip from generator.
REQ-015 SHALL have port chip_out  out  1  registered chip.
REQ-016 SHALL have port chip_valid  out  1  chip_out qualifier.
REQ-017 SHALL have port chip_id  out  2  requester owning chip_out/epoch/done.
REQ-018 SHALL have port epoch  out  1  high with last chip of epoch.
REQ-019 SHALL have port done  out  1  one-cycle pulse, epoch completed.

Function
REQ-020 SHALL implement states IDLE, LOAD, RUN, DONE; all outputs registered.
REQ-021 IDLE: if any req bit set, SHALL grant by round-robin starting at index (last_grant+1) mod 4; after reset, search starts at index 0.
REQ-022 Grant cycle: gnt[i]=1 for one cycle; last_grant=i; cac_prn and chip_id latched from requester i.
REQ-023 PRN valid range 1..32; on a PRN of 0 or 33..63, SHALL pulse err together with gnt, remain in IDLE, and leave cac_rst/cac_enb low.
REQ-024 Valid grant: SHALL enter LOAD; cac_rst=1 for exactly LOAD_CYC cycles; cac_enb=0 throughout.
REQ-025 LOAD->RUN: cac_enb=1 for exactly CODE_LEN consecutive cycles; chip counter 0..CODE_LEN-1, width ceil(log2(CODE_LEN)).
REQ-026 Each RUN cycle SHALL sample cac_chip; chip_out/chip_valid/chip_id SHALL appear on the next cycle (latency 1).
REQ-027 epoch SHALL be high with the chip_valid beat for counter value CODE_LEN-1 only.
REQ-028 RUN->DONE after last enable cycle; done=1 for one cycle in DONE; the next state is IDLE.
REQ-029 cac_prn SHALL remain stable from grant through DONE.
REQ-030 abort high in LOAD or RUN: next cycle SHALL be IDLE with cac_enb=0 and cac_rst=0; no done, no epoch; a chip sampled in the abort cycle is not output.
REQ-031 abort in IDLE or DONE SHALL be ignored.
REQ-032 req changes after grant SHALL NOT affect the current epoch; a requester still asserting req re-competes in IDLE.
REQ-033 Minimum gap between epochs SHALL be 1 IDLE cycle (DONE->IDLE->grant).

Reset
REQ-034 rst=0 SHALL asynchronously force: state IDLE, gnt=0, err=0, busy=0, cac_rst=1, cac_prn=0, cac_enb=0, chip_out=0, chip_valid=0, chip_id=0, epoch=0, done=0, last_grant=3.
REQ-035 cac_rst SHALL drop to 0 on the first clock edge after rst releases.
REQ-036 Reset mid-RUN SHALL discard the epoch with no done pulse.

Verification
REQ-037 req=0001, PRN0=1 -> gnt=0001; cac_rst high 2 cycles; 1023 chip_valid beats, chip_id=0; epoch on the last beat; done 1 cycle later.
REQ-038 req=1111, all PRNs valid, held -> grants in order 0,1,2,3,0; each epoch 1023 beats with the matching chip_id.
REQ-039 req=0010, PRN1=0 -> gnt=0010 with err=1; cac_enb never asserted; the next grant goes to an index >1 if requested.
REQ-040 abort at chip 500 -> cac_enb=0 the next cycle, 500 valid beats total, no epoch, no done; a new grant follows.
REQ-041 rst=0 at chip 200, asynchronously between edges -> all outputs reach reset values immediately; after release, req=0001 is granted index 0.
REQ-042 The PRN input for a granted requester changes during RUN -> cac_prn unchanged until DONE.
